// File: rtl/program_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : program_loader_pkg
//  Description : Shared state encoding and sizing constants for the program
//                loader and its word counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package program_loader_pkg;

  // Memory geometry and stream width
  localparam int MEM_DEPTH = 512;
  localparam int CNT_W     = 10;   // wide enough to hold a count of 512
  localparam int DATA_W    = 16;

  // Loader frame state machine
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    I_HDR  = 3'd1,
    I_BODY = 3'd2,
    D_HDR  = 3'd3,
    D_BODY = 3'd4,
    START  = 3'd5,
    DONE   = 3'd6,
    ERR    = 3'd7
  } state_t;

  // True for every state between frame acceptance and DONE/ERR
  function automatic logic is_busy_state(input state_t s);
    return (s == I_HDR) || (s == I_BODY) || (s == D_HDR) ||
           (s == D_BODY) || (s == START);
  endfunction

  // True for the states that consume stream words
  function automatic logic is_ready_state(input state_t s);
    return (s == I_HDR) || (s == I_BODY) || (s == D_HDR) || (s == D_BODY);
  endfunction

endpackage
`default_nettype wire

// File: rtl/program_loader_word_counter.sv
`default_nettype none
// ============================================================================
//  Module      : loader_word_counter
//  Description : Loadable remaining-word down-counter paired with an
//                up-counting write address. Shared by both memory images.
//  Revision    : 1.0 - initial release
// ============================================================================
module loader_word_counter #(
  parameter int CNT_W  = 10,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [CNT_W-1:0]  load_val,
  input  logic              dec,
  output logic [CNT_W-1:0]  value,
  output logic [ADDR_W-1:0] addr,
  output logic              zero
);

  logic [CNT_W-1:0]  value_q, value_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  // Load restarts the image at address 0; each consumed word advances both
  always_comb begin
    value_d = value_q;
    addr_d  = addr_q;
    if (load) begin
      value_d = load_val;
      addr_d  = '0;
    end else if (dec) begin
      value_d = value_q - CNT_W'(1);
      addr_d  = addr_q + ADDR_W'(1);
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
      addr_q  <= '0;
    end else begin
      value_q <= value_d;
      addr_q  <= addr_d;
    end
  end

  assign value = value_q;
  assign addr  = addr_q;
  assign zero  = (value_q == '0);

endmodule
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : program_loader
//  Description : Receives a framed word stream (instruction count, words,
//                data count, words), writes both images into the processor
//                memories and then issues a one-cycle start pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module program_loader #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_req,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] iram_in_ext,
  output logic              mem_write_ins,
  output logic [DATA_W-1:0] data_in_ext,
  output logic              mem_write_data_ext,
  output logic              start,
  output logic              busy,
  output logic              err
);

  import program_loader_pkg::*;

  // Largest image that fits; anything above is rejected at the header
  localparam logic [DATA_W-1:0] MAX_WORDS = DATA_W'(MEM_DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] iram_q, iram_d;
  logic [DATA_W-1:0] dmem_q, dmem_d;
  logic              wr_ins_q, wr_ins_d;
  logic              wr_dat_q, wr_dat_d;
  logic              start_q, start_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic              xfer;
  logic              cnt_load;
  logic              cnt_dec;
  logic [CNT_W-1:0]  cnt_value;
  logic [ADDR_W-1:0] cnt_addr;
  logic              cnt_zero;
  logic              hdr_too_big;
  logic              hdr_empty;

  loader_word_counter #(
    .CNT_W  (CNT_W),
    .ADDR_W (ADDR_W)
  ) u_word_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (in_data[CNT_W-1:0]),
    .dec      (cnt_dec),
    .value    (cnt_value),
    .addr     (cnt_addr),
    .zero     (cnt_zero)
  );

  // Ready depends on state only, so the upstream never sees a comb loop
  assign in_ready    = is_ready_state(state_q);
  assign xfer        = in_valid && in_ready;
  assign hdr_too_big = (in_data > MAX_WORDS);
  assign hdr_empty   = (in_data == '0);

  // Next-state and registered-output computation
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    iram_d     = iram_q;
    dmem_d     = dmem_q;
    wr_ins_d   = 1'b0;
    wr_dat_d   = 1'b0;
    start_d    = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (load_req) begin
          state_d = I_HDR;
        end
      end

      I_HDR: begin
        if (xfer) begin
          if (hdr_too_big) begin
            state_d = ERR;
          end else begin
            cnt_load = 1'b1;
            state_d  = hdr_empty ? D_HDR : I_BODY;
          end
        end
      end

      // The zero guard is defensive: a body is only entered with a nonzero count
      I_BODY: begin
        if (xfer && !cnt_zero) begin
          wr_ins_d   = 1'b1;
          iram_d     = in_data;
          mem_addr_d = cnt_addr;
          cnt_dec    = 1'b1;
          if (cnt_value == CNT_W'(1)) begin
            state_d = D_HDR;
          end
        end
      end

      D_HDR: begin
        if (xfer) begin
          if (hdr_too_big) begin
            state_d = ERR;
          end else begin
            cnt_load = 1'b1;
            state_d  = hdr_empty ? START : D_BODY;
          end
        end
      end

      D_BODY: begin
        if (xfer && !cnt_zero) begin
          wr_dat_d   = 1'b1;
          dmem_d     = in_data;
          mem_addr_d = cnt_addr;
          cnt_dec    = 1'b1;
          if (cnt_value == CNT_W'(1)) begin
            state_d = START;
          end
        end
      end

      // Registered start lands one cycle after the final write strobe
      START: begin
        start_d = 1'b1;
        state_d = DONE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = is_busy_state(state_d);
    err_d  = (state_d == ERR);
  end

  // State and output registers; reset also kills any pending write strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mem_addr_q <= '0;
      iram_q     <= '0;
      dmem_q     <= '0;
      wr_ins_q   <= 1'b0;
      wr_dat_q   <= 1'b0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      iram_q     <= iram_d;
      dmem_q     <= dmem_d;
      wr_ins_q   <= wr_ins_d;
      wr_dat_q   <= wr_dat_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign mem_addr           = mem_addr_q;
  assign iram_in_ext        = iram_q;
  assign mem_write_ins      = wr_ins_q;
  assign data_in_ext        = dmem_q;
  assign mem_write_data_ext = wr_dat_q;
  assign start              = start_q;
  assign busy               = busy_q;
  assign err                = err_q;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_program_loader
//  Description : Directed self-checking bench for program_loader.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_program_loader;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 16;

  logic              clk      = 1'b0;
  logic              rst_n    = 1'b0;
  logic              load_req = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data  = '0;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] iram_in_ext;
  logic              mem_write_ins;
  logic [DATA_W-1:0] data_in_ext;
  logic              mem_write_data_ext;
  logic              start;
  logic              busy;
  logic              err;

  int errors = 0;
  int checks = 0;

  program_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .load_req           (load_req),
    .in_valid           (in_valid),
    .in_data            (in_data),
    .in_ready           (in_ready),
    .mem_addr           (mem_addr),
    .iram_in_ext        (iram_in_ext),
    .mem_write_ins      (mem_write_ins),
    .data_in_ext        (data_in_ext),
    .mem_write_data_ext (mem_write_data_ext),
    .start              (start),
    .busy               (busy),
    .err                (err)
  );

  always #5 clk = ~clk;

  // Write/start monitor, sampled on the falling edge
  logic        xfer_last = 1'b0;
  int          cyc = 0;
  logic [24:0] iq[$];
  logic [24:0] dq[$];
  int          start_cnt = 0;
  int          both_cnt = 0;
  int          spurious_cnt = 0;
  int          start_cyc = -1;
  int          last_d_cyc = -1;

  always @(posedge clk) xfer_last <= in_valid && in_ready;

  always @(negedge clk) begin
    cyc++;
    if (mem_write_ins) iq.push_back({mem_addr, iram_in_ext});
    if (mem_write_data_ext) begin
      dq.push_back({mem_addr, data_in_ext});
      last_d_cyc = cyc;
    end
    if (mem_write_ins && mem_write_data_ext) both_cnt++;
    if ((mem_write_ins || mem_write_data_ext) && !xfer_last) spurious_cnt++;
    if (start) begin
      start_cnt++;
      start_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    iq.delete();
    dq.delete();
    start_cnt = 0;
    both_cnt = 0;
    spurious_cnt = 0;
    start_cyc = -1;
    last_d_cyc = -1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a falling edge; returns at the falling edge after the transfer
  task automatic send(input logic [DATA_W-1:0] w);
    int t = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("send_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  logic [DATA_W-1:0] img[512];

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;

    // ---------------- reset state
    idle(3);
    rst_n = 1'b1;
    idle(2);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_start", {31'd0, start}, 32'd0);
    chk("rst_wr_ins", {31'd0, mem_write_ins}, 32'd0);
    chk("rst_addr", {23'd0, mem_addr}, 32'd0);
    clear_mon();

    // ---------------- nominal frame
    pulse_load();
    chk("nom_busy", {31'd0, busy}, 32'd1);
    chk("nom_ready", {31'd0, in_ready}, 32'd1);
    send(16'd3); send(16'hA001); send(16'hA002); send(16'hA003);
    send(16'd2); send(16'hD001); send(16'hD002);
    in_valid = 1'b0;
    idle(5);
    chk("nom_icount", iq.size(), 32'd3);
    chk("nom_i0", {7'd0, iq[0]}, {7'd0, 9'd0, 16'hA001});
    chk("nom_i1", {7'd0, iq[1]}, {7'd0, 9'd1, 16'hA002});
    chk("nom_i2", {7'd0, iq[2]}, {7'd0, 9'd2, 16'hA003});
    chk("nom_dcount", dq.size(), 32'd2);
    chk("nom_d0", {7'd0, dq[0]}, {7'd0, 9'd0, 16'hD001});
    chk("nom_d1", {7'd0, dq[1]}, {7'd0, 9'd1, 16'hD002});
    chk("nom_starts", start_cnt, 32'd1);
    chk("nom_start_lat", start_cyc, last_d_cyc + 1);
    chk("nom_busy_end", {31'd0, busy}, 32'd0);
    chk("nom_both", both_cnt, 32'd0);
    chk("nom_spurious", spurious_cnt, 32'd0);
    clear_mon();

    // ---------------- empty images
    pulse_load();
    send(16'd0); send(16'd0);
    in_valid = 1'b0;
    idle(5);
    chk("empty_writes", iq.size() + dq.size(), 32'd0);
    chk("empty_starts", start_cnt, 32'd1);
    chk("empty_err", {31'd0, err}, 32'd0);
    chk("empty_busy", {31'd0, busy}, 32'd0);
    clear_mon();

    // ---------------- oversize header
    pulse_load();
    send(16'h0201);
    in_valid = 1'b0;
    chk("over_err", {31'd0, err}, 32'd1);
    chk("over_ready", {31'd0, in_ready}, 32'd0);
    idle(3);
    chk("over_busy", {31'd0, busy}, 32'd0);
    chk("over_writes", iq.size() + dq.size(), 32'd0);
    chk("over_starts", start_cnt, 32'd0);
    pulse_load();
    chk("over_err_clr", {31'd0, err}, 32'd0);
    send(16'd1); send(16'hB001); send(16'd1); send(16'hC001);
    in_valid = 1'b0;
    idle(5);
    chk("rec_icount", iq.size(), 32'd1);
    chk("rec_i0", {7'd0, iq[0]}, {7'd0, 9'd0, 16'hB001});
    chk("rec_d0", {7'd0, dq[0]}, {7'd0, 9'd0, 16'hC001});
    chk("rec_starts", start_cnt, 32'd1);
    clear_mon();

    // ---------------- full depth with random stalls
    for (int i = 0; i < 512; i++) img[i] = DATA_W'($urandom);
    pulse_load();
    send(16'd512);
    for (int i = 0; i < 512; i++) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        in_data  = DATA_W'($urandom);
        @(negedge clk);
      end
      send(img[i]);
    end
    send(16'd0);
    in_valid = 1'b0;
    idle(5);
    chk("full_icount", iq.size(), 32'd512);
    bad = 0;
    for (int i = 0; i < 512 && i < iq.size(); i++) begin
      if (iq[i] !== {i[8:0], img[i]}) bad++;
    end
    chk("full_order", bad, 32'd0);
    chk("full_spurious", spurious_cnt, 32'd0);
    chk("full_starts", start_cnt, 32'd1);
    clear_mon();

    // ---------------- load_req while busy
    pulse_load();
    send(16'd4); send(16'h1111); send(16'h2222);
    load_req = 1'b1;
    send(16'h3333);
    load_req = 1'b0;
    chk("lbusy_busy", {31'd0, busy}, 32'd1);
    send(16'h4444); send(16'd1); send(16'h5555);
    in_valid = 1'b0;
    idle(5);
    chk("lbusy_icount", iq.size(), 32'd4);
    chk("lbusy_i2", {7'd0, iq[2]}, {7'd0, 9'd2, 16'h3333});
    chk("lbusy_i3", {7'd0, iq[3]}, {7'd0, 9'd3, 16'h4444});
    chk("lbusy_d0", {7'd0, dq[0]}, {7'd0, 9'd0, 16'h5555});
    chk("lbusy_starts", start_cnt, 32'd1);
    clear_mon();

    // ---------------- reset mid-frame
    pulse_load();
    send(16'd4); send(16'h6666); send(16'h7777);
    in_valid = 1'b0;
    chk("mid_pending", {31'd0, mem_write_ins}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_wr_ins", {31'd0, mem_write_ins}, 32'd0);
    chk("mid_addr", {23'd0, mem_addr}, 32'd0);
    chk("mid_idata", {16'd0, iram_in_ext}, 32'd0);
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_ready", {31'd0, in_ready}, 32'd0);
    idle(3);
    rst_n = 1'b1;
    idle(4);
    chk("post_ready", {31'd0, in_ready}, 32'd0);
    chk("post_busy", {31'd0, busy}, 32'd0);
    chk("post_starts", start_cnt, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
